// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states and default datapath widths,
// used by the fetch controller, the PC logic and the instruction memory.
package cpu_pkg;

    localparam int unsigned DEF_ADDR_W  = 10;
    localparam int unsigned DEF_INSTR_W = 9;
    localparam int unsigned DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_controller.sv
// Instruction fetch controller in front of a synchronous (1-cycle latency) instruction memory.
// The next fetch address goes straight out on imem_addr, so fetch runs with zero bubbles on
// sequential flow and on redirects.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, start_pc  begin fetching at start_pc (from IDLE or HALTED)
//   imem_addr        address to the instruction memory (combinational)
//   imem_data        memory read data for last cycle's imem_addr
//   instr, instr_pc  instruction presented to decode and its address
//   instr_valid      instr/instr_pc valid (RUN only)
//   instr_ready      decode accepts; handshake = instr_valid & instr_ready
//   br_taken, br_target  redirect request and target
//   halt_req         stop fetching
//   done             high while HALTED
//   fetch_count      number of accepted instructions, saturating
module fetch_controller
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               halt_req,
    output logic               done,
    output logic [CNT_W-1:0]   fetch_count
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] next_addr;
    logic              handshake;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, next-address and output logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        handshake = (state_q == ST_RUN) && instr_ready;

        // Address issued now is the pc presented next cycle, which keeps instr aligned to pc.
        next_addr = pc_q;
        if (br_taken) begin
            next_addr = br_target;
        end else if (handshake) begin
            next_addr = pc_q + ADDR_W'(1);
        end

        imem_addr = start_pc;

        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = start_pc;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                imem_addr = next_addr;
                if (handshake && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Halt beats redirect; a same-cycle handshake still counts.
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else begin
                    pc_d = next_addr;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign instr       = imem_data;
    assign instr_pc    = pc_q;
    assign instr_valid = (state_q == ST_RUN);
    assign done        = (state_q == ST_HALTED);
    assign fetch_count = cnt_q;

endmodule : fetch_controller
